wb_stage: RTL

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/rv32i_types.sv | 54 +++++
 rtl/wb_stage_load_extract.sv | 29 ++
 rtl/wb_stage.sv | 100 ++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: regfile mux selects, load funct3 codes,
// the RVFI retire record and the MEM/WB pipeline word.
package rv32i_types;

  typedef enum logic [3:0] {
    rf_alu_out  = 4'd0,
    rf_br_en    = 4'd1,
    rf_u_imm    = 4'd2,
    rf_lw       = 4'd3,
    rf_pc_plus4 = 4'd4,
    rf_lb       = 4'd5,
    rf_lbu      = 4'd6,
    rf_lh       = 4'd7,
    rf_lhu      = 4'd8
  } regfilemux_sel_t;

  typedef enum logic [2:0] {
    lf_lb  = 3'b000,
    lf_lh  = 3'b001,
    lf_lw  = 3'b010,
    lf_lbu = 3'b100,
    lf_lhu = 3'b101
  } load_funct3_t;

  typedef struct packed {
    logic            load_regfile;
    regfilemux_sel_t regfilemux_sel;
  } ctrl_wd_t;

  typedef struct packed {
    logic        rvfi_valid;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn;
    logic [4:0]  rvfi_rd_addr;
    logic [31:0] rvfi_rd_wdata;
    logic [31:0] rvfi_pc_rdata;
    logic [31:0] rvfi_pc_wdata;
    logic [31:0] rvfi_mem_addr;
    logic [3:0]  rvfi_mem_rmask;
    logic [31:0] rvfi_mem_rdata;
  } rvfi_data_t;

  typedef struct packed {
    ctrl_wd_t    ctrl_wd;
    logic        cmp_out;
    logic [31:0] u_imm;
    logic [4:0]  rd;
    logic [31:0] alu_out;
    logic [31:0] mar;
    logic [31:0] mdr;
    rvfi_data_t  rvfi_d;
  } MEM_WB_stage_t;

endpackage

// File: rtl/wb_stage_load_extract.sv
// Sub-word load extraction: picks a byte/half of mdr by address and extends it.
// A misaligned half uses mar[1] only; no trap is raised here.
module load_extract
  import rv32i_types::*;
(
  input  logic [31:0]  mdr,
  input  logic [1:0]   mar,
  input  load_funct3_t sel,
  output logic [31:0]  value
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = mdr[{mar, 3'b000} +: 8];
  assign half_v = mdr[{mar[1], 4'b0000} +: 16];

  always_comb begin
    value = mdr;
    case (sel)
      lf_lb:   value = {{24{byte_v[7]}}, byte_v};
      lf_lbu:  value = {24'b0, byte_v};
      lf_lh:   value = {{16{half_v[15]}}, half_v};
      lf_lhu:  value = {16'b0, half_v};
      default: value = mdr;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, regfile write mux, single-shot retire.
// Optional RVFI monitor output and 64-bit order counter under RVFI_MON_EN.
module wb_stage
  import rv32i_types::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  MEM_WB_stage_t wb_in,
  output logic          rd_wen,
  output logic [4:0]    rd_addr,
  output logic [31:0]   rd_wdata,
  output logic          commit
`ifdef RVFI_MON_EN
  ,output rvfi_data_t   rvfi_out
`endif
);

  MEM_WB_stage_t word_q;
  logic          valid_q;
  logic          done_q;
  load_funct3_t  ext_sel;
  logic [31:0]   ext_val;

  // done_q marks a held instruction that already retired, so a long stall
  // produces exactly one commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (stall) begin
      if (commit) done_q <= 1'b1;
    end else if (flush) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      word_q  <= wb_in;
      valid_q <= wb_in.rvfi_d.rvfi_valid;
      done_q  <= 1'b0;
    end
  end

  assign commit  = valid_q & ~done_q;
  assign rd_addr = word_q.rd;
  assign rd_wen  = commit & (word_q.rd != 5'd0) & word_q.ctrl_wd.load_regfile;

  always_comb begin
    ext_sel = lf_lw;
    case (word_q.ctrl_wd.regfilemux_sel)
      rf_lb:   ext_sel = lf_lb;
      rf_lbu:  ext_sel = lf_lbu;
      rf_lh:   ext_sel = lf_lh;
      rf_lhu:  ext_sel = lf_lhu;
      default: ext_sel = lf_lw;
    endcase
  end

  load_extract u_ext (
    .mdr   (word_q.mdr),
    .mar   (word_q.mar[1:0]),
    .sel   (ext_sel),
    .value (ext_val)
  );

  always_comb begin
    rd_wdata = word_q.alu_out;
    case (word_q.ctrl_wd.regfilemux_sel)
      rf_alu_out:                   rd_wdata = word_q.alu_out;
      rf_br_en:                     rd_wdata = {31'b0, word_q.cmp_out};
      rf_u_imm:                     rd_wdata = word_q.u_imm;
      rf_pc_plus4:                  rd_wdata = word_q.rvfi_d.rvfi_pc_rdata + 32'd4;
      rf_lw:                        rd_wdata = word_q.mdr;
      rf_lb, rf_lbu, rf_lh, rf_lhu: rd_wdata = ext_val;
      default:                      rd_wdata = word_q.alu_out;
    endcase
  end

`ifdef RVFI_MON_EN
  logic [63:0] order_q;

  always_ff @(posedge clk) begin
    if (rst)         order_q <= '0;
    else if (commit) order_q <= order_q + 64'd1;
  end

  always_comb begin
    rvfi_out               = word_q.rvfi_d;
    rvfi_out.rvfi_valid    = commit;
    rvfi_out.rvfi_order    = order_q;
    rvfi_out.rvfi_rd_addr  = rd_wen ? rd_addr : 5'd0;
    rvfi_out.rvfi_rd_wdata = rd_wen ? rd_wdata : 32'd0;
  end
`else
  logic unused_rvfi;
  assign unused_rvfi = ^{word_q.rvfi_d, word_q.mar[31:2]};
`endif

endmodule
